// File: rtl/clint_responder_pkg.sv
// Shared constants, FSM state type and byte-strobe helper for the CLINT responder.
package clint_responder_pkg;

  // System configuration defaults
  localparam logic [31:0] clint_base_addr = 32'h0200_0000;
  localparam int unsigned clk_divider_rtc = 4;

  // Register offsets within the CLINT window (bits [15:0] of addr - base)
  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  // mtimecmp resets to all ones so no timer interrupt is pending out of reset
  localparam logic [63:0] MtimecmpRst = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {StIdle, StResp} clint_state_e;

  // Replace the bytes of old selected by wstrb with the matching bytes of wdata
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_rtc_tick.sv
// RTC tick generator: one-cycle tick every 2*(RTC_DIV+1) core clocks.
module clint_rtc_tick
  import clint_responder_pkg::*;
#(
  parameter int unsigned RTC_DIV = clk_divider_rtc
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (RTC_DIV > 0) ? $clog2(RTC_DIV + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RTC_DIV);

  logic [CntW-1:0] cnt_q;
  logic            phase_q;

  // Count 0..RTC_DIV, toggling the phase bit on each wrap
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CntMax) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // High in the cycle whose closing edge takes the phase from 1 to 0
  assign tick = phase_q && (cnt_q == CntMax);

endmodule

// File: rtl/clint_responder.sv
// CLINT responder: msip, mtimecmp and mtime registers behind a valid/ready bus.
module clint_responder
  import clint_responder_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = clint_base_addr,
  parameter int unsigned RTC_DIV    = clk_divider_rtc
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clint_valid,
  input  logic        clint_instr,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);

  clint_state_e state_q;
  logic [31:0]  rdata_q;
  logic         ready_q;
  logic         msip_q;
  logic         mtip_q;
  logic [63:0]  mtime_q;
  logic [63:0]  mtime_d;
  logic [63:0]  mtimecmp_q;

  logic         tick;
  logic [31:0]  offset;
  logic [15:0]  reg_off;
  logic         access;
  logic         is_write;
  logic [31:0]  rd_data;
  logic         unused_bits;

  clint_rtc_tick #(
    .RTC_DIV(RTC_DIV)
  ) u_rtc_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign offset   = clint_addr - CLINT_BASE;
  assign reg_off  = offset[15:0];
  // Requests are only accepted in IDLE, so a held valid cannot re-trigger during RESP
  assign access   = (state_q == StIdle) && clint_valid;
  assign is_write = |clint_wstrb;
  // Fetches are served like data reads; upper offset bits are not decoded
  assign unused_bits = ^{clint_instr, offset[31:16]};

  // Read mux; mtime is returned as it stands before any same-cycle tick
  always_comb begin
    rd_data = '0;
    case (reg_off)
      CLINT_MSIP:        rd_data = {31'b0, msip_q};
      CLINT_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
      CLINT_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
      CLINT_MTIME_LO:    rd_data = mtime_q[31:0];
      CLINT_MTIME_HI:    rd_data = mtime_q[63:32];
      default:           rd_data = '0;
    endcase
  end

  // mtime next state: a software write to either half overrides the tick entirely
  always_comb begin
    mtime_d = mtime_q;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (access && is_write) begin
      if (reg_off == CLINT_MTIME_LO) begin
        mtime_d = {mtime_q[63:32], apply_wstrb(mtime_q[31:0], clint_wdata, clint_wstrb)};
      end else if (reg_off == CLINT_MTIME_HI) begin
        mtime_d = {apply_wstrb(mtime_q[63:32], clint_wdata, clint_wstrb), mtime_q[31:0]};
      end
    end
  end

  // Architectural registers and registered timer compare
  always_ff @(posedge clock) begin
    if (reset) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= MtimecmpRst;
      mtime_q    <= '0;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      mtip_q  <= (mtime_q >= mtimecmp_q);
      if (access && is_write) begin
        case (reg_off)
          CLINT_MSIP: begin
            if (clint_wstrb[0]) msip_q <= clint_wdata[0];
          end
          CLINT_MTIMECMP_LO: begin
            mtimecmp_q[31:0] <= apply_wstrb(mtimecmp_q[31:0], clint_wdata, clint_wstrb);
          end
          CLINT_MTIMECMP_HI: begin
            mtimecmp_q[63:32] <= apply_wstrb(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
          end
          default: ;
        endcase
      end
    end
  end

  // Bus FSM: accept in IDLE, answer with a one-cycle ready pulse in RESP
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (clint_valid) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            rdata_q <= rd_data;
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign clint_rdata = rdata_q;
  assign clint_ready = ready_q;
  assign clint_msip  = msip_q;
  assign clint_mtip  = mtip_q;
  assign clint_mtime = mtime_q;

endmodule

// File: tb/tb_clint_responder.sv
// Self-checking bench for clint_responder: directed table, hand sequences, random traffic.
module tb_clint_responder;

  localparam logic [31:0] Base   = 32'h0200_0000;
  localparam int unsigned Div    = 4;
  localparam int unsigned Period = 2 * (Div + 1);

  logic        clock;
  logic        reset;
  logic        clint_valid;
  logic        clint_instr;
  logic [31:0] clint_addr;
  logic [31:0] clint_wdata;
  logic [3:0]  clint_wstrb;
  logic [31:0] clint_rdata;
  logic        clint_ready;
  logic        clint_msip;
  logic        clint_mtip;
  logic [63:0] clint_mtime;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;

  clint_responder #(
    .CLINT_BASE(Base),
    .RTC_DIV   (Div)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clint_valid(clint_valid),
    .clint_instr(clint_instr),
    .clint_addr (clint_addr),
    .clint_wdata(clint_wdata),
    .clint_wstrb(clint_wstrb),
    .clint_rdata(clint_rdata),
    .clint_ready(clint_ready),
    .clint_msip (clint_msip),
    .clint_mtip (clint_mtip),
    .clint_mtime(clint_mtime)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (register-map level) ----------------
  int unsigned m_cyc   = 0;   // clock edges since reset released
  logic [63:0] m_mtime = '0;
  logic [63:0] m_cmp   = '1;
  logic        m_msip  = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_mtip  = 1'b0;
  logic        m_wasrd = 1'b0;
  logic [31:0] m_rdata = '0;

  logic [15:0] m_off;
  logic        m_acc;
  logic        m_tick;
  logic [63:0] m_nt;

  function automatic logic [31:0] mmerge(input logic [31:0] old_val, input logic [31:0] wd,
                                         input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_val & ~m) | (wd & m);
  endfunction

  function automatic logic [31:0] mread(input logic [15:0] off);
    case (off)
      16'h0000: return {31'b0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[31:0];
      16'hBFFC: return m_mtime[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  always_comb begin
    m_off  = 16'(clint_addr - Base);
    m_acc  = clint_valid && !m_ready;
    m_tick = ((m_cyc + 32'd1) % Period) == 32'd0;
    m_nt   = m_tick ? m_mtime + 64'd1 : m_mtime;
    if (m_acc && clint_wstrb != 4'h0 && m_off == 16'hBFF8)
      m_nt = {m_mtime[63:32], mmerge(m_mtime[31:0], clint_wdata, clint_wstrb)};
    if (m_acc && clint_wstrb != 4'h0 && m_off == 16'hBFFC)
      m_nt = {mmerge(m_mtime[63:32], clint_wdata, clint_wstrb), m_mtime[31:0]};
  end

  always @(posedge clock) begin
    if (reset) begin
      m_cyc <= 0; m_mtime <= '0; m_cmp <= '1; m_msip <= 1'b0;
      m_ready <= 1'b0; m_mtip <= 1'b0; m_wasrd <= 1'b0; m_rdata <= '0;
    end else begin
      m_cyc   <= m_cyc + 1;
      m_mtime <= m_nt;
      m_mtip  <= (m_mtime >= m_cmp);
      m_ready <= m_acc;
      if (m_acc) begin
        m_rdata <= mread(m_off);
        m_wasrd <= (clint_wstrb == 4'h0);
        if (clint_wstrb != 4'h0) begin
          if (m_off == 16'h0000 && clint_wstrb[0]) m_msip <= clint_wdata[0];
          if (m_off == 16'h4000) m_cmp[31:0]  <= mmerge(m_cmp[31:0], clint_wdata, clint_wstrb);
          if (m_off == 16'h4004) m_cmp[63:32] <= mmerge(m_cmp[63:32], clint_wdata, clint_wstrb);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (chk_en) begin
      check("m_ready", clint_ready, m_ready);
      if (m_ready && m_wasrd) check("m_rdata", clint_rdata, m_rdata);
      check("m_msip", clint_msip, m_msip);
      check("m_mtip", clint_mtip, m_mtip);
      check("m_mtime", clint_mtime, m_mtime);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus(input logic [15:0] off, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd);
    bit got;
    got = 0;
    rd  = '0;
    @(negedge clock);
    clint_valid = 1'b1;
    clint_addr  = Base + {16'h0, off};
    clint_wdata = wd;
    clint_wstrb = ws;
    clint_instr = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clock);
      if (clint_ready) begin
        got = 1;
        rd  = clint_rdata;
      end
    end
    clint_valid = 1'b0;
    check("bus_ready_seen", 64'(got), 64'd1);
  endtask

  typedef struct {
    logic [15:0] off;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_msip;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] off, input logic [31:0] wd, input logic [3:0] ws,
                     input logic chk, input logic [31:0] er, input logic em);
    vec_t v;
    v.off = off; v.wdata = wd; v.wstrb = ws; v.chk_rd = chk; v.exp_rd = er; v.exp_msip = em;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          nresp;
    bit          seen;

    reset = 1'b1; clint_valid = 1'b0; clint_instr = 1'b0;
    clint_addr = '0; clint_wdata = '0; clint_wstrb = '0;
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    chk_en = 1;

    // Reset values, then 100 idle clocks -> mtime = 10
    check("rst_ready", clint_ready, 0);
    check("rst_rdata", clint_rdata, 0);
    check("rst_mtime", clint_mtime, 0);
    repeat (100) @(posedge clock);
    @(negedge clock);
    check("idle100_mtime", clint_mtime, 64'd10);
    check("idle100_mtip", clint_mtip, 0);
    check("idle100_msip", clint_msip, 0);

    // Timer compare at 20
    bus(16'h4004, 32'h0, 4'hF, rd);
    bus(16'h4000, 32'd20, 4'hF, rd);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (clint_mtime == 64'd20) seen = 1;
    end
    check("mtip_wait_mtime20", 64'(seen), 64'd1);
    check("mtip_before", clint_mtip, 0);
    repeat (2) @(negedge clock);
    check("mtip_rise", clint_mtip, 1);
    bus(16'h4000, 32'hFFFF_FFFF, 4'hF, rd);
    @(negedge clock);
    check("mtip_fall", clint_mtip, 0);
    bus(16'h4004, 32'hFFFF_FFFF, 4'hF, rd);

    // Held valid: exactly two responses over four edges
    @(negedge clock);
    check("hold_ready0", clint_ready, 0);
    clint_valid = 1'b1; clint_addr = Base + 32'h4000; clint_wdata = 32'hAB; clint_wstrb = 4'hF;
    nresp = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      check("hold_ready_pattern", clint_ready, 64'(i % 2));
      if (clint_ready) nresp++;
    end
    clint_valid = 1'b0;
    check("hold_responses", 64'(nresp), 64'd2);
    @(negedge clock);
    check("hold_ready_after", clint_ready, 0);
    bus(16'h4000, 32'h0, 4'h0, rd);
    check("hold_readback", rd, 32'hAB);

    // Directed register table
    add(16'h0000, 32'h1,         4'b0001, 0, 32'h0,         1);
    add(16'h0000, 32'h0,         4'b0000, 1, 32'h1,         1);
    add(16'h0000, 32'h0,         4'b0001, 0, 32'h0,         0);
    add(16'h0000, 32'h1,         4'b0010, 0, 32'h0,         0);
    add(16'h0000, 32'h0,         4'b0000, 1, 32'h0,         0);
    add(16'h0000, 32'hFFFF_FFFF, 4'b1111, 0, 32'h0,         1);
    add(16'h0000, 32'h0,         4'b0000, 1, 32'h1,         1);
    add(16'h0000, 32'hFFFF_FFFE, 4'b1111, 0, 32'h0,         0);
    add(16'h4000, 32'h1234_5678, 4'b1111, 0, 32'h0,         0);
    add(16'h4004, 32'hAABB_CCDD, 4'b1111, 0, 32'h0,         0);
    add(16'h4000, 32'h0,         4'b0000, 1, 32'h1234_5678, 0);
    add(16'h4004, 32'h0,         4'b0000, 1, 32'hAABB_CCDD, 0);
    add(16'h4000, 32'h0000_00EE, 4'b0001, 0, 32'h0,         0);
    add(16'h4004, 32'h9900_0000, 4'b1000, 0, 32'h0,         0);
    add(16'h4000, 32'h0,         4'b0000, 1, 32'h1234_56EE, 0);
    add(16'h4004, 32'h0,         4'b0000, 1, 32'h99BB_CCDD, 0);
    add(16'h1234, 32'h0,         4'b0000, 1, 32'h0,         0);
    add(16'h1234, 32'hDEAD_BEEF, 4'b1111, 0, 32'h0,         0);
    add(16'h1234, 32'h0,         4'b0000, 1, 32'h0,         0);
    add(16'h4000, 32'hFFFF_FFFF, 4'b1111, 0, 32'h0,         0);
    add(16'h4004, 32'hFFFF_FFFF, 4'b1111, 0, 32'h0,         0);
    add(16'hBFFC, 32'h0,         4'b0000, 1, 32'h0,         0);
    foreach (tbl[i]) begin
      bus(tbl[i].off, tbl[i].wdata, tbl[i].wstrb, rd);
      if (tbl[i].chk_rd) check("tbl_rdata", rd, tbl[i].exp_rd);
      check("tbl_msip", clint_msip, tbl[i].exp_msip);
    end

    // mtime wrap
    bus(16'hBFFC, 32'hFFFF_FFFF, 4'hF, rd);
    bus(16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd);
    check("wrap_written", clint_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    seen = 0;
    for (int i = 0; i < 2 * Period && !seen; i++) begin
      @(negedge clock);
      if (clint_mtime != 64'hFFFF_FFFF_FFFF_FFFF) seen = 1;
    end
    check("wrap_changed", 64'(seen), 64'd1);
    check("wrap_zero", clint_mtime, 64'h0);

    // Write landing on a tick edge: written value stands, tick lost
    seen = 0;
    for (int i = 0; i < 2 * Period && !seen; i++) begin
      @(negedge clock);
      if (((m_cyc + 32'd2) % Period) == 32'd0) seen = 1;
    end
    check("tickwr_aligned", 64'(seen), 64'd1);
    bus(16'hBFF8, 32'h55, 4'hF, rd);
    check("tickwr_value", clint_mtime, 64'h55);
    repeat (Period) @(negedge clock);
    check("tickwr_next", clint_mtime, 64'h56);

    // Randomized traffic, including held and back-to-back valid
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] a;
      int          sel;
      @(negedge clock);
      sel = $urandom_range(0, 5);
      case (sel)
        0:       a = 16'h0000;
        1:       a = 16'h4000;
        2:       a = 16'h4004;
        3:       a = 16'hBFF8;
        4:       a = 16'hBFFC;
        default: a = 16'($urandom);
      endcase
      clint_valid = ($urandom_range(0, 2) != 0);
      clint_addr  = Base + {16'h0, a};
      clint_wdata = $urandom;
      clint_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      clint_instr = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    clint_valid = 1'b0;
    repeat (3) @(negedge clock);

    // Reset during the response cycle
    bus(16'h0000, 32'h1, 4'b0001, rd);
    bus(16'h4004, 32'h0, 4'hF, rd);
    bus(16'h4000, 32'h0, 4'hF, rd);
    @(negedge clock);
    clint_valid = 1'b1; clint_addr = Base + 32'h4000; clint_wstrb = 4'h0;
    @(negedge clock);
    check("rstresp_ready_before", clint_ready, 1);
    clint_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("rstresp_ready", clint_ready, 0);
    check("rstresp_rdata", clint_rdata, 0);
    check("rstresp_msip", clint_msip, 0);
    check("rstresp_mtip", clint_mtip, 0);
    check("rstresp_mtime", clint_mtime, 0);
    reset = 1'b0;
    bus(16'h4000, 32'h0, 4'h0, rd);
    check("rstresp_cmp_lo", rd, 32'hFFFF_FFFF);
    bus(16'h4004, 32'h0, 4'h0, rd);
    check("rstresp_cmp_hi", rd, 32'hFFFF_FFFF);
    bus(16'h0000, 32'h0, 4'h0, rd);
    check("rstresp_msip_rd", rd, 32'h0);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
